// File: rtl/trap_ctrl_if.sv
// Signal bundle between trap_ctrl and its neighbours (ID, CSR file, fetch redirect).
// The slave modport is the trap controller's view; master is the surrounding pipeline.
interface trap_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             inst_valid_i;
    logic [XLEN-1:0]  inst_pc_i;
    logic             ecall_i;
    logic             mret_i;
    logic             illegal_i;
    logic             irq_timer_i;
    logic             mstatus_mie_i;
    logic             csr_rw_req_i;
    logic             csr_rw_gnt_o;
    logic             pipe_drained_i;
    logic [1:0]       csr_state_o;
    logic [XLEN-1:0]  csr_pc_o;
    logic [XLEN-1:0]  csr_cause_o;
    logic [XLEN-1:0]  csr_dnpc_i;
    logic             stall_o;
    logic             flush_o;
    logic             redirect_valid_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             redirect_ready_i;
    logic             busy_o;
    logic [CNT_W-1:0] trap_cnt_o;

    modport slave (
        input  inst_valid_i, inst_pc_i, ecall_i, mret_i, illegal_i,
        input  irq_timer_i, mstatus_mie_i, csr_rw_req_i, pipe_drained_i,
        input  csr_dnpc_i, redirect_ready_i,
        output csr_rw_gnt_o, csr_state_o, csr_pc_o, csr_cause_o,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        output busy_o, trap_cnt_o
    );

    modport master (
        output inst_valid_i, inst_pc_i, ecall_i, mret_i, illegal_i,
        output irq_timer_i, mstatus_mie_i, csr_rw_req_i, pipe_drained_i,
        output csr_dnpc_i, redirect_ready_i,
        input  csr_rw_gnt_o, csr_state_o, csr_pc_o, csr_cause_o,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        input  busy_o, trap_cnt_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains the pipe, issues the trap-entry or mret CSR
// command, then redirects fetch to the CSR-supplied PC. Also arbitrates CSR rw access.
module trap_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    trap_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ENTER,
        RET,
        REDIR
    } state_t;

    localparam logic [XLEN-1:0]  CAUSE_IRQ     = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [XLEN-1:0]  CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0]  CAUSE_ECALL   = XLEN'(11);
    localparam logic [XLEN-1:0]  PC_ALIGN_MASK = ~XLEN'(3);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    state_t           state;
    logic [XLEN-1:0]  saved_pc;
    logic [XLEN-1:0]  saved_cause;
    logic             saved_mret;
    logic [1:0]       cmd_q;
    logic [XLEN-1:0]  csr_pc_q;
    logic [XLEN-1:0]  csr_cause_q;
    logic             flush_q;
    logic             busy_q;
    logic             redir_valid_q;
    logic [XLEN-1:0]  redir_pc_q;
    logic [CNT_W-1:0] trap_cnt_q;

    logic             irq_take;
    logic             evt_any;
    logic             accept;
    logic             evt_mret;
    logic [XLEN-1:0]  evt_cause;
    logic             rw_gnt;

    assign irq_take = bus.irq_timer_i && bus.mstatus_mie_i;
    assign evt_any  = irq_take || bus.illegal_i || bus.ecall_i || bus.mret_i;
    assign accept   = (state == IDLE) && bus.inst_valid_i && evt_any;

    // Highest-priority event wins; mret is only honoured when nothing traps.
    always_comb begin
        evt_cause = '0;
        evt_mret  = 1'b0;
        if (irq_take) begin
            evt_cause = CAUSE_IRQ;
        end else if (bus.illegal_i) begin
            evt_cause = CAUSE_ILLEGAL;
        end else if (bus.ecall_i) begin
            evt_cause = CAUSE_ECALL;
        end else if (bus.mret_i) begin
            evt_mret = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            saved_pc      <= '0;
            saved_cause   <= '0;
            saved_mret    <= 1'b0;
            cmd_q         <= 2'b00;
            csr_pc_q      <= '0;
            csr_cause_q   <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            trap_cnt_q    <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= DRAIN;
                        flush_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        saved_pc    <= bus.inst_pc_i;
                        saved_cause <= evt_cause;
                        saved_mret  <= evt_mret;
                    end
                end
                DRAIN: begin
                    if (bus.pipe_drained_i) begin
                        if (saved_mret) begin
                            state <= RET;
                            cmd_q <= 2'b11;
                        end else begin
                            state       <= ENTER;
                            cmd_q       <= 2'b10;
                            csr_pc_q    <= saved_pc;
                            csr_cause_q <= saved_cause;
                        end
                    end
                end
                ENTER, RET: begin
                    state         <= REDIR;
                    cmd_q         <= 2'b00;
                    csr_pc_q      <= '0;
                    csr_cause_q   <= '0;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= bus.csr_dnpc_i & PC_ALIGN_MASK;
                end
                REDIR: begin
                    if (bus.redirect_ready_i) begin
                        state         <= IDLE;
                        busy_q        <= 1'b0;
                        redir_valid_q <= 1'b0;
                        if (!saved_mret && (trap_cnt_q != CNT_MAX)) begin
                            trap_cnt_q <= trap_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall and grant react to the acceptance in the same cycle, so they stay combinational.
    assign rw_gnt               = bus.csr_rw_req_i && (state == IDLE) && !accept;
    assign bus.csr_rw_gnt_o     = rw_gnt;
    assign bus.csr_state_o      = rw_gnt ? 2'b01 : cmd_q;
    assign bus.csr_pc_o         = csr_pc_q;
    assign bus.csr_cause_o      = csr_cause_q;
    assign bus.stall_o          = busy_q || accept;
    assign bus.flush_o          = flush_q;
    assign bus.redirect_valid_o = redir_valid_q;
    assign bus.redirect_pc_o    = redir_pc_q;
    assign bus.busy_o           = busy_q;
    assign bus.trap_cnt_o       = trap_cnt_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences the machine-mode CSR file for trap entry (ecall, illegal instruction, timer interrupt) and for trap return (mret).
- Drains the pipeline, issues the one-cycle CSR state command, then captures the CSR-supplied next PC and hands it to fetch as a redirect.
- Arbitrates the CSR command port between ordinary CSR read/write instructions from ID and its own trap sequencing.
- Sits between ID, the CSR file and the fetch/redirect logic.

Parameters:
XLEN, 64, width of PCs, cause and CSR data
CNT_W, 32, width of the saturating trap counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
inst_valid_i  input  1  ID holds a valid instruction this cycle
inst_pc_i  input  XLEN  PC of that instruction
ecall_i  input  1  instruction is ecall
mret_i  input  1  instruction is mret
illegal_i  input  1  instruction is illegal
irq_timer_i  input  1  machine timer interrupt pending (level)
mstatus_mie_i  input  1  mstatus.MIE from the CSR file
csr_rw_req_i  input  1  ID requests a CSR read/write
csr_rw_gnt_o  output  1  CSR read/write granted this cycle
pipe_drained_i  input  1  all older instructions have retired
csr_state_o  output  2  CSR command: 00 idle, 01 rw, 10 trap entry, 11 mret
csr_pc_o  output  XLEN  PC to be written to mepc on trap entry
csr_cause_o  output  XLEN  mcause value on trap entry
csr_dnpc_i  input  XLEN  CSR-supplied next PC (mtvec or mepc)
stall_o  output  1  hold ID/IF
flush_o  output  1  one-cycle pulse that kills younger instructions
redirect_valid_o  output  1  redirect request to fetch
redirect_pc_o  output  XLEN  redirect target
redirect_ready_i  input  1  fetch accepts the redirect
busy_o  output  1  FSM is not in IDLE
trap_cnt_o  output  CNT_W  number of trap entries completed (saturating)

Behaviour:
Reset and handshake basics:
- Reset is asynchronous and active-low. Every output, register and the FSM clear to 0 / IDLE.
- A reset asserted mid-sequence drops any pending redirect immediately. No CSR command is issued afterwards.

Event detection (IDLE only, requires inst_valid_i):
- Priority order: interrupt (irq_timer_i && mstatus_mie_i), then illegal_i, then ecall_i, then mret_i.
- Cause values: interrupt = {1'b1, 59'b0, 4'd7}; illegal = 2; ecall = 11.
- On acceptance, inst_pc_i is latched as the saved PC and the cause is latched. The interrupted or faulting instruction does not execute.
- In all non-IDLE states the event inputs are ignored. An interrupt that deasserts after acceptance does not abort the sequence.

FSM states:
- IDLE: on an accepted event go to DRAIN.
- DRAIN: flush_o pulses for exactly the first cycle in DRAIN. Stay until pipe_drained_i = 1; then go to ENTER for a trap or RET for mret. If pipe_drained_i is already 1 on the first cycle, leave DRAIN after that one cycle.
- ENTER: lasts one cycle. Drive csr_state_o = 10, csr_pc_o = latched PC, csr_cause_o = latched cause. Register csr_dnpc_i into the redirect target. Go to REDIR.
- RET: lasts one cycle. Drive csr_state_o = 11 and register csr_dnpc_i. Go to REDIR.
- REDIR: hold redirect_valid_o = 1 with redirect_pc_o stable until redirect_ready_i = 1. Then return to IDLE. On a trap (not mret), trap_cnt_o increments, saturating at all-ones.

Output rules:
- Redirect target = {csr_dnpc_i[XLEN-1:2], 2'b00}; mtvec mode bits are ignored.
- stall_o = (state != IDLE) || event accepted this cycle. This term is combinational, so the stall applies in the same cycle as acceptance.
- busy_o = (state != IDLE).
- csr_rw_gnt_o = csr_rw_req_i && IDLE && no event accepted this cycle. An accepted trap event wins over a CSR read/write in the same cycle.
- csr_state_o = 01 only while csr_rw_gnt_o is high. Outside ENTER and RET it is otherwise 00.
- csr_pc_o and csr_cause_o are 0 outside ENTER.
- The redirect back to IDLE and a new event are never accepted in the same cycle: the first possible new acceptance is the cycle after REDIR exits.

Test Plan:
1. Ecall at pc 0x8000_0010 with pipe_drained_i = 1 and csr_dnpc_i = 0x8000_0103 -> flush pulse, ENTER with csr_pc_o = 0x8000_0010 and csr_cause_o = 0xB, then redirect_pc_o = 0x8000_0100. Hold redirect_ready_i = 0 for 3 cycles -> redirect_valid_o stays 1 with a stable PC; trap_cnt_o = 1 after ready.
2. Mret with csr_dnpc_i = 0x8000_0014 -> csr_state_o = 11 for one cycle, redirect to 0x8000_0014, trap_cnt_o unchanged.
3. irq_timer_i = 1, mstatus_mie_i = 1 and ecall_i = 1 together at pc 0x200 -> csr_cause_o = 0x8000_0000_0000_0007, csr_pc_o = 0x200. Repeat with mstatus_mie_i = 0 -> cause 0xB.
4. Illegal instruction with pipe_drained_i low for 4 cycles -> stall_o high throughout, exactly one flush pulse, ENTER occurs the cycle after drain, cause = 2.
5. csr_rw_req_i together with ecall -> csr_rw_gnt_o = 0. A lone csr_rw_req_i in IDLE -> grant = 1 and csr_state_o = 01 in the same cycle.
6. Assert rst_n low during REDIR -> redirect_valid_o drops immediately and FSM returns to IDLE. Separately, preload trap_cnt_o to all-ones via forced traps with CNT_W = 2 -> the count holds at 3.
